// File: rtl/line_window_gen.sv
// line_window_gen: streaming 3x3 window generator over raster pixels using two line buffers.
// Emits one registered window per interior pixel position and a done strobe at frame end.
module line_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             busy,
    output logic             win_valid,
    output logic [PIX_W-1:0] sw_pixels1,
    output logic [PIX_W-1:0] sw_pixels2,
    output logic [PIX_W-1:0] sw_pixels3,
    output logic [PIX_W-1:0] sw_pixels4,
    output logic [PIX_W-1:0] sw_pixels5,
    output logic [PIX_W-1:0] sw_pixels6,
    output logic [PIX_W-1:0] sw_pixels7,
    output logic [PIX_W-1:0] sw_pixels8,
    output logic [PIX_W-1:0] sw_pixels9,
    output logic             done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [PIX_W-1:0] top_q [3];
    logic [PIX_W-1:0] top_d [3];
    logic [PIX_W-1:0] mid_q [3];
    logic [PIX_W-1:0] mid_d [3];
    logic [PIX_W-1:0] bot_q [3];
    logic [PIX_W-1:0] bot_d [3];
    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] win_d [9];
    logic             win_valid_q, win_valid_d;
    logic             done_q, done_d;
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];
    logic             accept, last_col, last_row;

    assign accept   = (state_q == BUSY) && in_valid;
    assign last_col = col_q == CW'(IMG_W - 1);
    assign last_row = row_q == RW'(IMG_H - 1);

    // Line buffers are never reset: every location is rewritten before it can reach a window.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col_q] <= lb1[col_q];
            lb1[col_q] <= in_pixel;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        top_d       = top_q;
        mid_d       = mid_q;
        bot_d       = bot_q;
        win_d       = win_q;
        win_valid_d = 1'b0;
        done_d      = 1'b0;
        if (state_q == IDLE && start) begin
            state_d = BUSY;
            col_d   = '0;
            row_d   = '0;
        end
        if (accept) begin
            col_d = last_col ? '0 : col_q + 1'b1;
            row_d = last_col ? (last_row ? '0 : row_q + 1'b1) : row_q;
            top_d = '{top_q[1], top_q[2], lb2[col_q]};
            mid_d = '{mid_q[1], mid_q[2], lb1[col_q]};
            bot_d = '{bot_q[1], bot_q[2], in_pixel};
            // Columns 0 and 1 still carry the previous line's tail, so they never emit.
            if (row_q >= RW'(2) && col_q >= CW'(2)) begin
                win_valid_d = 1'b1;
                win_d = '{top_d[0], top_d[1], top_d[2],
                          mid_d[0], mid_d[1], mid_d[2],
                          bot_d[0], bot_d[1], bot_d[2]};
            end
            if (last_col && last_row) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            top_q       <= '{default: '0};
            mid_q       <= '{default: '0};
            bot_q       <= '{default: '0};
            win_q       <= '{default: '0};
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            top_q       <= top_d;
            mid_q       <= mid_d;
            bot_q       <= bot_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            done_q      <= done_d;
        end
    end

    assign busy       = state_q == BUSY;
    assign win_valid  = win_valid_q;
    assign done       = done_q;
    assign sw_pixels1 = win_q[0];
    assign sw_pixels2 = win_q[1];
    assign sw_pixels3 = win_q[2];
    assign sw_pixels4 = win_q[3];
    assign sw_pixels5 = win_q[4];
    assign sw_pixels6 = win_q[5];
    assign sw_pixels7 = win_q[6];
    assign sw_pixels8 = win_q[7];
    assign sw_pixels9 = win_q[8];
endmodule
